// File: rtl/fetch_stage.sv
// Instruction fetch front end: single-word reads from main memory into a small
// FIFO, with {pc, insn} handed to decode and redirect-driven flushes.
module fetch_stage #(
    parameter int ADDRESS_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter logic [ADDRESS_SIZE-1:0] START_ADDRESS = 32'h80020000,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic                    redirect,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [1:0]              mem_acc_size,
    output logic                    mem_wren,
    output logic                    mem_enable,
    input  logic                    mem_busy,
    input  logic [DATA_SIZE-1:0]    mem_d_out,
    output logic                    insn_valid,
    output logic [DATA_SIZE-1:0]    insn,
    output logic [ADDRESS_SIZE-1:0] insn_pc,
    input  logic                    insn_ready,
    output logic                    state_dbg
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] pc;
    logic [ADDRESS_SIZE-1:0] inflight_pc;
    logic                    inflight;
    logic                    drop;
    logic [ADDRESS_SIZE-1:0] fifo_pc   [FIFO_DEPTH];
    logic [DATA_SIZE-1:0]    fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [CNT_W-1:0]        count;
    logic                    credit_ok;
    logic                    issue;
    logic                    push;
    logic                    pop;

    // Decode handshake: the head transfers at the posedge where insn_valid and
    // insn_ready are both high; insn/insn_pc hold steady while valid && !ready.
    assign insn_valid = (count != '0);
    assign pop        = insn_valid && insn_ready;

    // Credits cover buffered entries plus the outstanding request, so a
    // response always finds a free slot; !inflight keeps one request in flight.
    assign credit_ok = (count + CNT_W'(inflight)) < CNT_W'(FIFO_DEPTH);
    assign issue     = (state == RUN) && !mem_busy && !redirect && !inflight && credit_ok;
    assign push      = inflight && !drop && !redirect;

    assign mem_enable   = issue;
    assign mem_addr     = pc;
    assign mem_acc_size = 2'b00;
    assign mem_wren     = 1'b0;

    assign insn      = insn_valid ? fifo_data[rd_ptr] : '0;
    assign insn_pc   = insn_valid ? fifo_pc[rd_ptr] : '0;
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= START_ADDRESS;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            drop        <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE:    if (run) state <= RUN;
                RUN:     if (!run) state <= IDLE;
                default: state <= IDLE;
            endcase

            inflight <= issue;
            if (issue) inflight_pc <= pc;
            drop <= redirect && inflight;

            if (redirect) begin
                pc     <= redirect_pc & ~ADDRESS_SIZE'(3);
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (issue) pc <= pc + ADDRESS_SIZE'(4);
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc[wr_ptr]   <= inflight_pc;
            fifo_data[wr_ptr] <= mem_d_out;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle checks on the memory port plus a
// scoreboard of expected {pc, insn} heads popped by a negedge monitor.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] mem_addr;
    logic [1:0]  mem_acc_size;
    logic        mem_wren;
    logic        mem_enable;
    logic        mem_busy = 1'b0;
    logic [31:0] mem_d_out = '0;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready = 1'b0;
    logic        state_dbg;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];

    localparam logic [31:0] START = 32'h80020000;

    fetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .run         (run),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_acc_size(mem_acc_size),
        .mem_wren    (mem_wren),
        .mem_enable  (mem_enable),
        .mem_busy    (mem_busy),
        .mem_d_out   (mem_d_out),
        .insn_valid  (insn_valid),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .insn_ready  (insn_ready),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h80020000) return 32'h11111111;
        if (a == 32'h80020004) return 32'h22222222;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory model: read data appears the cycle after an accepted request.
    always @(posedge clk) begin
        if (mem_enable && !mem_busy) mem_d_out <= mem_word(mem_addr);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && insn_valid && insn_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL head_unexpected: got %h_%h expected none", insn_pc, insn);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({insn_pc, insn} !== e) begin
                    n_bad++;
                    $display("FAIL head: got %h_%h expected %h_%h", insn_pc, insn, e[63:32], e[31:0]);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    task automatic do_reset();
        cyc();
        reset = 1'b1;
        run = 1'b0;
        insn_ready = 1'b0;
        redirect = 1'b0;
        mem_busy = 1'b0;
        cyc();
        look();
        check("rst_valid", insn_valid, 0);
        check("rst_enable", mem_enable, 0);
        check("rst_pc", mem_addr, START);
        check("rst_insn", insn, 0);
        check("rst_insn_pc", insn_pc, 0);
        check("rst_state", state_dbg, 0);
        check("rst_acc_size", mem_acc_size, 0);
        check("rst_wren", mem_wren, 0);
        cyc();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n_iss;
        logic [31:0] a0, a1;

        // Basic fetch: first issue in cycle 1, first head in cycle 3
        do_reset();
        run = 1'b1;
        insn_ready = 1'b1;
        exp_q.push_back({32'h80020000, 32'h11111111});
        exp_q.push_back({32'h80020004, 32'h22222222});
        look();
        check("t1_c0_enable", mem_enable, 0);
        check("t1_c0_state", state_dbg, 0);
        cyc(); look();
        check("t1_c1_enable", mem_enable, 1);
        check("t1_c1_addr", mem_addr, 32'h80020000);
        check("t1_c1_state", state_dbg, 1);
        cyc(); look();
        check("t1_c2_enable", mem_enable, 0);
        check("t1_c2_valid", insn_valid, 0);
        cyc(); look();
        check("t1_c3_valid", insn_valid, 1);
        check("t1_c3_enable", mem_enable, 1);
        check("t1_c3_addr", mem_addr, 32'h80020004);
        cyc(); look();
        check("t1_c4_valid", insn_valid, 0);
        cyc(); look();
        check("t1_c5_valid", insn_valid, 1);

        // Back-pressure: FIFO fills after two requests, then drains in order
        do_reset();
        run = 1'b1;
        insn_ready = 1'b0;
        exp_q.push_back({32'h80020000, 32'h11111111});
        exp_q.push_back({32'h80020004, 32'h22222222});
        exp_q.push_back({32'h80020008, 32'h0008C0DE});
        n_iss = 0;
        a0 = '0;
        a1 = '0;
        for (int i = 0; i < 10; i++) begin
            look();
            if (mem_enable) begin
                if (n_iss == 0) a0 = mem_addr;
                if (n_iss == 1) a1 = mem_addr;
                n_iss++;
            end
            cyc();
        end
        check("t2_issue_count", n_iss, 2);
        check("t2_addr0", a0, 32'h80020000);
        check("t2_addr1", a1, 32'h80020004);
        insn_ready = 1'b1;
        look();
        check("t2_full_enable", mem_enable, 0);
        check("t2_full_pc", mem_addr, 32'h80020008);
        check("t2_full_valid", insn_valid, 1);
        cyc(); look();
        check("t2_resume_enable", mem_enable, 1);
        check("t2_resume_addr", mem_addr, 32'h80020008);
        cyc(); look();
        check("t2_gap_valid", insn_valid, 0);
        cyc(); look();
        check("t2_third_valid", insn_valid, 1);

        // Redirect while a request is in flight and one entry is buffered
        do_reset();
        run = 1'b1;
        insn_ready = 1'b0;
        cyc(); cyc(); cyc(); look();
        check("t3_c3_valid", insn_valid, 1);
        check("t3_c3_addr", mem_addr, 32'h80020004);
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h80020103;
        exp_q.push_back({32'h80020100, 32'h0100C0DE});
        look();
        check("t3_r_enable", mem_enable, 0);
        cyc();
        redirect = 1'b0;
        insn_ready = 1'b1;
        look();
        check("t3_r1_valid", insn_valid, 0);
        check("t3_r1_enable", mem_enable, 1);
        check("t3_r1_addr", mem_addr, 32'h80020100);
        check("t3_r1_state", state_dbg, 1);
        cyc(); look();
        check("t3_r2_valid", insn_valid, 0);
        cyc(); look();
        check("t3_r3_valid", insn_valid, 1);
        check("t3_r3_pc", insn_pc, 32'h80020100);

        // mem_busy stalls issue; a response during busy is still captured
        do_reset();
        run = 1'b1;
        insn_ready = 1'b1;
        mem_busy = 1'b1;
        exp_q.push_back({32'h80020000, 32'h11111111});
        for (int i = 0; i < 5; i++) begin
            look();
            check("t4_busy_enable", mem_enable, 0);
            check("t4_busy_pc", mem_addr, START);
            cyc();
        end
        mem_busy = 1'b0;
        look();
        check("t4_free_enable", mem_enable, 1);
        check("t4_free_addr", mem_addr, START);
        cyc();
        mem_busy = 1'b1;
        look();
        check("t4_resp_enable", mem_enable, 0);
        cyc(); look();
        check("t4_head_valid", insn_valid, 1);
        check("t4_head_enable", mem_enable, 0);
        check("t4_head_pc", mem_addr, 32'h80020004);

        // Simultaneous push/pop at occupancy 1, then run low and drain
        do_reset();
        run = 1'b1;
        insn_ready = 1'b0;
        exp_q.push_back({32'h80020000, 32'h11111111});
        exp_q.push_back({32'h80020004, 32'h22222222});
        exp_q.push_back({32'h80020008, 32'h0008C0DE});
        cyc(); cyc(); cyc(); look();
        check("t5_c3_valid", insn_valid, 1);
        check("t5_c3_enable", mem_enable, 1);
        cyc();
        insn_ready = 1'b1;
        look();
        check("t5_c4_valid", insn_valid, 1);
        cyc();
        insn_ready = 1'b0;
        run = 1'b0;
        look();
        check("t5_c5_valid", insn_valid, 1);
        check("t5_c5_pc", insn_pc, 32'h80020004);
        check("t5_c5_enable", mem_enable, 1);
        check("t5_c5_addr", mem_addr, 32'h80020008);
        cyc(); look();
        check("t5_c6_state", state_dbg, 0);
        check("t5_c6_enable", mem_enable, 0);
        cyc();
        insn_ready = 1'b1;
        look();
        check("t5_c7_valid", insn_valid, 1);
        cyc(); look();
        check("t5_c8_pc", insn_pc, 32'h80020008);
        for (int i = 0; i < 3; i++) begin
            cyc(); look();
            check("t5_drained_valid", insn_valid, 0);
            check("t5_drained_enable", mem_enable, 0);
        end

        // Reset mid-stream: buffered entry and in-flight response both vanish
        do_reset();
        run = 1'b1;
        insn_ready = 1'b0;
        cyc(); cyc(); cyc(); look();
        check("t6_c3_valid", insn_valid, 1);
        check("t6_c3_enable", mem_enable, 1);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        insn_ready = 1'b1;
        exp_q.push_back({32'h80020000, 32'h11111111});
        look();
        check("t6_after_valid", insn_valid, 0);
        check("t6_after_pc", mem_addr, START);
        check("t6_after_enable", mem_enable, 0);
        check("t6_after_state", state_dbg, 0);
        cyc(); look();
        check("t6_late_valid", insn_valid, 0);
        check("t6_reissue_enable", mem_enable, 1);
        check("t6_reissue_addr", mem_addr, START);
        cyc(); cyc(); look();
        check("t6_head_valid", insn_valid, 1);

        cyc(); cyc();
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch front end that drives the main-memory read port with single-word reads (acc_size 2'b00).
- Holds the PC, starting at START_ADDRESS, and buffers returned words in a small FIFO.
- Presents {pc, insn} pairs to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream and discards stale in-flight data after a redirect.

Parameters:
ADDRESS_SIZE  32  width of PC and memory address
DATA_SIZE  32  instruction word width
START_ADDRESS  32'h80020000  PC value after reset
FIFO_DEPTH  2  instruction buffer entries (power of two, >=2)

Ports:
clk  in  1  clock; all logic on posedge
reset  in  1  synchronous, active-high reset
run  in  1  fetch enable; low = issue no new requests
redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  ADDRESS_SIZE  new PC; bits [1:0] forced to 0
mem_addr  out  ADDRESS_SIZE  read address to main memory
mem_acc_size  out  2  constant 2'b00 (single word)
mem_wren  out  1  constant 0
mem_enable  out  1  read request strobe
mem_busy  in  1  memory busy; no request issued while high
mem_d_out  in  DATA_SIZE  read data, valid the cycle after a request
insn_valid  out  1  FIFO head valid
insn  out  DATA_SIZE  FIFO head instruction
insn_pc  out  ADDRESS_SIZE  FIFO head PC
insn_ready  in  1  decode accepts head this cycle

Behaviour:
- Reset values: pc = START_ADDRESS, FIFO empty, insn_valid = 0, mem_enable = 0, inflight = 0, drop = 0, state = IDLE. insn and insn_pc read 0 while empty.
- Memory timing: a request is issued in cycle N when mem_enable = 1 and mem_busy = 0. mem_d_out is captured at the posedge ending cycle N+1. At most one request is outstanding.
- Issue condition, evaluated combinationally: state == RUN, !mem_busy, !redirect, and (occupancy + inflight) < FIFO_DEPTH.
  - When issuing: mem_enable = 1, mem_addr = pc.
  - At that posedge: pc <= pc + 4 (wraps modulo 2^ADDRESS_SIZE), inflight <= 1, inflight_pc <= pc.
- Response: in the cycle after an issue, the response is written to the FIFO as {inflight_pc, mem_d_out} unless drop = 1. inflight then clears.
- Pop: occurs at the posedge when insn_valid && insn_ready. Push and pop in the same cycle are both performed and occupancy is unchanged. Push is never attempted when full, because credit counting prevents it.
- Head outputs come straight from the FIFO registers; there is no extra latency.
- FSM:
  - IDLE: no issue; go to RUN when run = 1.
  - RUN: issue per the rule above; go to IDLE when run = 0. Outstanding responses still complete and the FIFO still drains.
  - Redirect is accepted in either state and does not change state.
- Redirect in cycle R:
  - No issue in cycle R.
  - At the posedge ending R: FIFO flushed (pointers reset, insn_valid = 0), pc <= {redirect_pc[ADDRESS_SIZE-1:2], 2'b00}.
  - If a request is outstanding, drop <= 1 so its response is discarded, then drop clears.
  - A pop in cycle R is still honoured; decode has already taken that entry.
  - First new request is issued in cycle R+1 at the earliest. First valid instruction appears in cycle R+3.
- Redirect coinciding with a response: the response is discarded.
- Redirect coinciding with reset: reset wins.
- Reset mid-burst: the outstanding response is ignored because inflight is cleared. The memory's d_out is don't-care.
- mem_busy high: issue stalls and pc holds; an outstanding response is still captured normally.
- Throughput: with insn_ready held at 1 and mem_busy at 0, one instruction per 2 cycles (single outstanding request).

Test Plan:
- Reset then run = 1, insn_ready = 1, memory preloaded with 0x11111111 and 0x22222222 at 0x80020000 and 0x80020004 -> mem_enable in cycle 1 with addr 0x80020000. insn_valid in cycle 3 with insn_pc 0x80020000, insn 0x11111111. Next head is 0x80020004 / 0x22222222.
- insn_ready = 0 for 10 cycles -> exactly 2 requests issued (0x80020000 and 0x80020004). FIFO full, mem_enable stays 0, pc = 0x80020008. On release, heads pop in order and fetch resumes at 0x80020008.
- Redirect to 0x80020103 while a request to 0x80020004 is in flight -> that response is dropped and the FIFO is emptied. Next request addr = 0x80020100. First valid head has insn_pc = 0x80020100, 3 cycles after the redirect.
- mem_busy held high for 4 cycles with the FIFO empty -> mem_enable = 0 and pc unchanged. Issue occurs in the first cycle busy drops.
- Simultaneous push and pop with occupancy 1 -> occupancy stays 1 and order is preserved. Then run = 0 -> no new issue, the FIFO drains, insn_valid falls.
- Assert reset for 1 cycle mid-stream with 1 entry buffered and 1 request in flight -> next cycle insn_valid = 0, pc = 0x80020000, and the late response is not pushed.
